// File: rtl/pc_ctrl.sv
// pc_ctrl -- fetch program-counter controller.
//
// Generates the instruction-fetch address and the pipeline flush/stall
// controls for the front end. After reset it spends one BOOT cycle idle,
// then fetches sequentially (PC += 4 on each accepted fetch). A taken jump
// from execute redirects the PC and flushes the front end for FLUSH_CYCLES
// cycles. A hold request from execute freezes fetch until it drops.
//
// Parameters
//   RESET_ADDR    PC value loaded while reset is asserted
//   FLUSH_CYCLES  cycles flush_o stays high after a taken jump (1..7)
//
// Ports
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   jump_en_i      in   taken-jump request from execute
//   jump_addr_i    in   jump target (bits [1:0] are dropped)
//   hold_flag_i    in   pipeline hold request from execute
//   fetch_ready_i  in   instruction memory accepts pc_o this cycle
//   pc_o           out  current fetch address
//   pc_valid_o     out  pc_o is a valid fetch request
//   flush_o        out  clear if_id / id_ex registers
//   stall_o        out  freeze if_id / id_ex registers
//   misalign_o     out  one-cycle pulse: accepted jump target not word aligned
//
// All outputs are registers; the flag outputs are decoded from the next
// state so they line up with the state they describe.
module pc_ctrl #(
    parameter logic [31:0] RESET_ADDR   = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    input  logic        fetch_ready_i,
    output logic [31:0] pc_o,
    output logic        pc_valid_o,
    output logic        flush_o,
    output logic        stall_o,
    output logic        misalign_o
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HOLD,
        S_FLUSH
    } state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [2:0]  r_cnt;
    logic        r_pc_valid;
    logic        r_flush;
    logic        r_stall;
    logic        r_misalign;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [2:0]  w_cnt_nxt;
    logic        w_misalign_nxt;

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_cnt_nxt      = r_cnt;
        w_misalign_nxt = 1'b0;

        // A jump outside BOOT wins over hold and over the fetch handshake.
        if ((r_state != S_BOOT) && jump_en_i) begin
            w_state_nxt    = S_FLUSH;
            w_pc_nxt       = {jump_addr_i[31:2], 2'b00};
            w_cnt_nxt      = FLUSH_LOAD;
            w_misalign_nxt = |jump_addr_i[1:0];
        end else begin
            case (r_state)
                S_BOOT: begin
                    w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (hold_flag_i) begin
                        w_state_nxt = S_HOLD;
                    end else if (r_pc_valid && fetch_ready_i) begin
                        w_pc_nxt = r_pc + 32'd4;
                    end
                end
                S_HOLD: begin
                    if (!hold_flag_i) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_FLUSH: begin
                    // hold_flag_i is only looked at on the last flush cycle.
                    if (r_cnt <= 3'd1) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = hold_flag_i ? S_HOLD : S_RUN;
                    end else begin
                        w_cnt_nxt = r_cnt - 3'd1;
                    end
                end
                default: begin
                    w_state_nxt = S_BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_ADDR;
            r_cnt      <= '0;
            r_pc_valid <= 1'b0;
            r_flush    <= 1'b0;
            r_stall    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pc_valid <= (w_state_nxt == S_RUN);
            r_flush    <= (w_state_nxt == S_FLUSH);
            r_stall    <= (w_state_nxt == S_HOLD);
            r_misalign <= w_misalign_nxt;
        end
    end

    assign pc_o       = r_pc;
    assign pc_valid_o = r_pc_valid;
    assign flush_o    = r_flush;
    assign stall_o    = r_stall;
    assign misalign_o = r_misalign;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed testbench for pc_ctrl (default parameters).
// Stimulus words are {jump_en, hold_flag, fetch_ready, jump_addr}; expected
// words are {pc, pc_valid, flush, stall, misalign}, sampled 1 ns after the
// rising edge that consumed the stimulus.
module tb_pc_ctrl;

    logic        clk           = 1'b0;
    logic        rst_n         = 1'b0;
    logic        jump_en_i     = 1'b0;
    logic [31:0] jump_addr_i   = '0;
    logic        hold_flag_i   = 1'b0;
    logic        fetch_ready_i = 1'b0;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        flush_o;
    logic        stall_o;
    logic        misalign_o;
    logic [35:0] obs;

    int tests_run    = 0;
    int tests_failed = 0;

    pc_ctrl #(
        .RESET_ADDR  (32'h0000_0000),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .jump_en_i    (jump_en_i),
        .jump_addr_i  (jump_addr_i),
        .hold_flag_i  (hold_flag_i),
        .fetch_ready_i(fetch_ready_i),
        .pc_o         (pc_o),
        .pc_valid_o   (pc_valid_o),
        .flush_o      (flush_o),
        .stall_o      (stall_o),
        .misalign_o   (misalign_o)
    );

    always #5 clk = ~clk;

    assign obs = {pc_o, pc_valid_o, flush_o, stall_o, misalign_o};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, release between edges, pass through BOOT: leaves DUT in RUN at pc 0.
    task automatic do_reset();
        {jump_en_i, hold_flag_i, fetch_ready_i, jump_addr_i} = '0;
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        tests_run++;
        if (obs !== {32'h0, 4'b0000}) begin
            tests_failed++;
            $display("FAIL reset_async: got %h expected %h", obs, {32'h0, 4'b0000});
        end
        tick();
        tests_run++;
        if (obs !== {32'h0, 4'b0000}) begin
            tests_failed++;
            $display("FAIL reset_edge: got %h expected %h", obs, {32'h0, 4'b0000});
        end
    endtask

    task automatic test_run_seq();
        logic [35:0] expv [4] = '{{32'h0, 4'b1000}, {32'h4, 4'b1000},
                                  {32'h8, 4'b1000}, {32'hC, 4'b1000}};
        fetch_ready_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (obs !== {32'h0, 4'b0000}) begin
            tests_failed++;
            $display("FAIL boot_cycle: got %h expected %h", obs, {32'h0, 4'b0000});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (obs !== expv[i]) begin
                tests_failed++;
                $display("FAIL run_seq[%0d]: got %h expected %h", i, obs, expv[i]);
            end
        end
    endtask

    task automatic test_boot_jump_ignored();
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n         = 1'b1;
        jump_en_i     = 1'b1;
        jump_addr_i   = 32'h300;
        fetch_ready_i = 1'b1;
        tick();
        tests_run++;
        if (obs !== {32'h0, 4'b1000}) begin
            tests_failed++;
            $display("FAIL boot_jump_ignored: got %h expected %h", obs, {32'h0, 4'b1000});
        end
        jump_en_i = 1'b0;
    endtask

    task automatic test_jump();
        logic [34:0] stim [7] = '{{3'b001, 32'h0}, {3'b000, 32'h0}, {3'b001, 32'h0},
                                  {3'b101, 32'h100}, {3'b001, 32'h0}, {3'b001, 32'h0},
                                  {3'b001, 32'h0}};
        logic [35:0] expv [7] = '{{32'h4, 4'b1000}, {32'h4, 4'b1000}, {32'h8, 4'b1000},
                                  {32'h100, 4'b0100}, {32'h100, 4'b0100},
                                  {32'h100, 4'b1000}, {32'h104, 4'b1000}};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            {jump_en_i, hold_flag_i, fetch_ready_i, jump_addr_i} = stim[i];
            tick();
            tests_run++;
            if (obs !== expv[i]) begin
                tests_failed++;
                $display("FAIL jump[%0d]: got %h expected %h", i, obs, expv[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [34:0] stim [5] = '{{3'b111, 32'h180}, {3'b101, 32'h200}, {3'b001, 32'h0},
                                  {3'b001, 32'h0}, {3'b001, 32'h0}};
        logic [35:0] expv [5] = '{{32'h180, 4'b0100}, {32'h200, 4'b0100},
                                  {32'h200, 4'b0100}, {32'h200, 4'b1000},
                                  {32'h204, 4'b1000}};
        for (int i = 0; i < 5; i++) begin
            {jump_en_i, hold_flag_i, fetch_ready_i, jump_addr_i} = stim[i];
            tick();
            tests_run++;
            if (obs !== expv[i]) begin
                tests_failed++;
                $display("FAIL back_to_back[%0d]: got %h expected %h", i, obs, expv[i]);
            end
        end
    endtask

    task automatic test_hold();
        logic [34:0] stim [8] = '{{3'b101, 32'h20}, {3'b001, 32'h0}, {3'b001, 32'h0},
                                  {3'b011, 32'h0}, {3'b011, 32'h0}, {3'b011, 32'h0},
                                  {3'b001, 32'h0}, {3'b001, 32'h0}};
        logic [35:0] expv [8] = '{{32'h20, 4'b0100}, {32'h20, 4'b0100}, {32'h20, 4'b1000},
                                  {32'h20, 4'b0010}, {32'h20, 4'b0010}, {32'h20, 4'b0010},
                                  {32'h20, 4'b1000}, {32'h24, 4'b1000}};
        for (int i = 0; i < 8; i++) begin
            {jump_en_i, hold_flag_i, fetch_ready_i, jump_addr_i} = stim[i];
            tick();
            tests_run++;
            if (obs !== expv[i]) begin
                tests_failed++;
                $display("FAIL hold[%0d]: got %h expected %h", i, obs, expv[i]);
            end
        end
    endtask

    task automatic test_flush_exit_hold();
        logic [34:0] stim [11] = '{{3'b101, 32'h40}, {3'b011, 32'h0}, {3'b011, 32'h0},
                                   {3'b001, 32'h0}, {3'b101, 32'h60}, {3'b011, 32'h0},
                                   {3'b001, 32'h0}, {3'b011, 32'h0}, {3'b111, 32'h80},
                                   {3'b001, 32'h0}, {3'b001, 32'h0}};
        logic [35:0] expv [11] = '{{32'h40, 4'b0100}, {32'h40, 4'b0100}, {32'h40, 4'b0010},
                                   {32'h40, 4'b1000}, {32'h60, 4'b0100}, {32'h60, 4'b0100},
                                   {32'h60, 4'b1000}, {32'h60, 4'b0010}, {32'h80, 4'b0100},
                                   {32'h80, 4'b0100}, {32'h80, 4'b1000}};
        for (int i = 0; i < 11; i++) begin
            {jump_en_i, hold_flag_i, fetch_ready_i, jump_addr_i} = stim[i];
            tick();
            tests_run++;
            if (obs !== expv[i]) begin
                tests_failed++;
                $display("FAIL flush_exit_hold[%0d]: got %h expected %h", i, obs, expv[i]);
            end
        end
    endtask

    task automatic test_misalign();
        logic [34:0] stim [6] = '{{3'b101, 32'h102}, {3'b001, 32'h0}, {3'b001, 32'h0},
                                  {3'b101, 32'h207}, {3'b001, 32'h0}, {3'b000, 32'h0}};
        logic [35:0] expv [6] = '{{32'h100, 4'b0101}, {32'h100, 4'b0100},
                                  {32'h100, 4'b1000}, {32'h204, 4'b0101},
                                  {32'h204, 4'b0100}, {32'h204, 4'b1000}};
        for (int i = 0; i < 6; i++) begin
            {jump_en_i, hold_flag_i, fetch_ready_i, jump_addr_i} = stim[i];
            tick();
            tests_run++;
            if (obs !== expv[i]) begin
                tests_failed++;
                $display("FAIL misalign[%0d]: got %h expected %h", i, obs, expv[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [34:0] stim [5] = '{{3'b101, 32'hFFFF_FFFC}, {3'b001, 32'h0}, {3'b001, 32'h0},
                                  {3'b001, 32'h0}, {3'b001, 32'h0}};
        logic [35:0] expv [5] = '{{32'hFFFF_FFFC, 4'b0100}, {32'hFFFF_FFFC, 4'b0100},
                                  {32'hFFFF_FFFC, 4'b1000}, {32'h0, 4'b1000},
                                  {32'h4, 4'b1000}};
        for (int i = 0; i < 5; i++) begin
            {jump_en_i, hold_flag_i, fetch_ready_i, jump_addr_i} = stim[i];
            tick();
            tests_run++;
            if (obs !== expv[i]) begin
                tests_failed++;
                $display("FAIL wrap[%0d]: got %h expected %h", i, obs, expv[i]);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        // Mid-FLUSH: assert reset between edges.
        {jump_en_i, hold_flag_i, fetch_ready_i, jump_addr_i} = {3'b101, 32'h300};
        tick();
        tests_run++;
        if (obs !== {32'h300, 4'b0100}) begin
            tests_failed++;
            $display("FAIL rst_flush_pre: got %h expected %h", obs, {32'h300, 4'b0100});
        end
        {jump_en_i, hold_flag_i, fetch_ready_i, jump_addr_i} = '0;
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (obs !== {32'h0, 4'b0000}) begin
            tests_failed++;
            $display("FAIL rst_flush_async: got %h expected %h", obs, {32'h0, 4'b0000});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (obs !== {32'h0, 4'b1000}) begin
            tests_failed++;
            $display("FAIL rst_flush_release: got %h expected %h", obs, {32'h0, 4'b1000});
        end
        // Mid-HOLD.
        hold_flag_i = 1'b1;
        tick();
        tests_run++;
        if (obs !== {32'h0, 4'b0010}) begin
            tests_failed++;
            $display("FAIL rst_hold_pre: got %h expected %h", obs, {32'h0, 4'b0010});
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (obs !== {32'h0, 4'b0000}) begin
            tests_failed++;
            $display("FAIL rst_hold_async: got %h expected %h", obs, {32'h0, 4'b0000});
        end
        hold_flag_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (obs !== {32'h0, 4'b1000}) begin
            tests_failed++;
            $display("FAIL rst_hold_release: got %h expected %h", obs, {32'h0, 4'b1000});
        end
    endtask

    initial begin
        test_reset();
        test_run_seq();
        test_boot_jump_ignored();
        test_jump();
        test_back_to_back();
        test_hold();
        test_flush_exit_hold();
        test_misalign();
        test_wrap();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within 100000 ns");
        $fatal(1);
    end

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 SHALL have parameter RESET_ADDR, default 32'h0000_0000, meaning the PC value loaded at reset.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, range 1..7, meaning the number of cycles flush_o stays high after a taken jump.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port jump_en_i, input, 1 bit: taken-jump request from the execute stage.
REQ-007 SHALL have port jump_addr_i, input, 32 bits: jump target from the execute stage.
REQ-008 SHALL have port hold_flag_i, input, 1 bit: pipeline hold request from the execute stage.
REQ-009 SHALL have port fetch_ready_i, input, 1 bit: instruction memory accepts the current pc_o.
REQ-010 SHALL have port pc_o, output, 32 bits: current fetch address.
REQ-011 SHALL have port pc_valid_o, output, 1 bit: pc_o is a valid fetch request.
REQ-012 SHALL have port flush_o, output, 1 bit: clear the if_id and id_ex pipeline registers.
REQ-013 SHALL have port stall_o, output, 1 bit: freeze the if_id and id_ex pipeline registers.
REQ-014 SHALL have port misalign_o, output, 1 bit: one-cycle pulse when an accepted jump target has bits [1:0] not equal to 0.

Function
REQ-015 SHALL implement the states BOOT, RUN, HOLD and FLUSH; all outputs SHALL be registered.
REQ-016 BOOT SHALL last exactly one cycle after reset release, hold pc_valid_o=0, then go to RUN.
REQ-017 In RUN, pc_valid_o SHALL be 1, and flush_o and stall_o SHALL be 0.
REQ-018 In RUN, a fetch handshake (pc_valid_o && fetch_ready_i) SHALL advance pc_o by 4 on the next edge; without the handshake, pc_o SHALL hold.
REQ-019 The PC increment SHALL be modulo 2^32: 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-020 jump_en_i=1 in RUN, HOLD or FLUSH SHALL, on the next edge, do all of the following:
- load pc_o with {jump_addr_i[31:2], 2'b00};
- enter FLUSH and load the flush counter with FLUSH_CYCLES;
- pulse misalign_o for one cycle if jump_addr_i[1:0] is not 2'b00.
REQ-021 jump_en_i SHALL take priority over hold_flag_i and over the fetch handshake in the same cycle; the sequential PC is discarded.
REQ-022 In FLUSH, flush_o SHALL be 1, pc_valid_o SHALL be 0, and pc_o SHALL hold; the counter decrements each cycle.
REQ-023 When the flush counter reaches 1, the next state SHALL be HOLD if hold_flag_i=1, otherwise RUN.
REQ-024 hold_flag_i in FLUSH SHALL only be evaluated at flush exit.
REQ-025 A new jump during FLUSH SHALL reload the target and restart the counter at FLUSH_CYCLES.
REQ-026 hold_flag_i=1 in RUN with jump_en_i=0 SHALL enter HOLD on the next edge; pc_o SHALL not advance even if fetch_ready_i=1.
REQ-027 In HOLD, stall_o SHALL be 1, pc_valid_o SHALL be 0, and pc_o SHALL hold; the block returns to RUN on the first edge with hold_flag_i=0.
REQ-028 flush_o and stall_o SHALL never be 1 in the same cycle.
REQ-029 jump_en_i in BOOT SHALL be ignored.

Reset
REQ-030 rst_n=0 SHALL immediately, independent of clk, force all of the following:
- pc_o = RESET_ADDR;
- pc_valid_o, flush_o, stall_o and misalign_o = 0;
- flush counter = 0;
- state = BOOT.
REQ-031 Reset asserted mid-FLUSH or mid-HOLD SHALL abandon the operation, with no residual flush or stall after release.

Verification
REQ-032 Reset release with fetch_ready_i=1 -> pc_o = 0x0 for 2 cycles (BOOT, then the first RUN fetch), then 0x4, 0x8, 0xC on consecutive cycles.
REQ-033 jump_en_i=1 with jump_addr_i=0x100 at pc 0x8 -> pc_o = 0x100 and flush_o=1 for exactly 2 cycles with pc_valid_o=0, then fetches resume at 0x100.
REQ-034 Hold and jump in the same cycle, then a second jump to 0x200 during the first flush cycle -> target 0x200, flush_o extended to 2 cycles from the second jump, stall_o stays 0.
REQ-035 hold_flag_i high for 3 cycles at pc 0x20 with fetch_ready_i=1 -> stall_o=1 for 3 cycles, pc_o stays 0x20, then advances to 0x24.
REQ-036 Jump to 0x102 -> pc_o = 0x100 and misalign_o=1 for one cycle.
REQ-037 Wrap and reset:
- jump to 0xFFFF_FFFC, then one fetch -> pc_o = 0x0;
- rst_n asserted mid-FLUSH -> all outputs reset asynchronously.
